// File: rtl/test_mem_mp_if.sv
// test_mem_mp_if: per-port val/rdy request/response bundle for the shared test memory
interface test_mem_mp_if #(parameter int N = 2);
  logic [N-1:0][76:0] req_msg;
  logic [N-1:0]       req_val;
  logic [N-1:0]       req_rdy;
  logic [N-1:0][46:0] resp_msg;
  logic [N-1:0]       resp_val;
  logic [N-1:0]       resp_rdy;
  modport master(output req_msg, req_val, resp_rdy, input req_rdy, resp_msg, resp_val);
  modport slave(input req_msg, req_val, resp_rdy, output req_rdy, resp_msg, resp_val);
endinterface

// File: rtl/test_mem_mp.sv
// test_mem_mp: multi-port shared-array test memory with per-port latency/response queues
module test_mem_mp #(
  parameter int p_num_ports = 2,
  parameter int p_mem_words = 4096,
  parameter int p_lat       = 1,
  parameter int p_depth     = 4
) (
  input logic          clk,
  input logic          rst,
  test_mem_mp_if.slave m
);
  localparam int AW = $clog2(p_mem_words);
  localparam int QW = p_depth > 1 ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);
  localparam int GW = $clog2(p_lat + 1);
  logic [31:0] mem_q [p_mem_words];
  logic [p_num_ports-1:0]         wr;
  logic [p_num_ports-1:0][AW-1:0] idx;
  logic [p_num_ports-1:0][3:0]    be;
  logic [p_num_ports-1:0][31:0]   wd;
  // ascending port order: the highest port index wins each byte on a same-edge collision
  always_ff @(posedge clk)
    for (int i = 0; i < p_num_ports; i++)
      for (int b = 0; b < 4; b++)
        if (wr[i] && be[i][b]) mem_q[idx[i]][8*b +: 8] <= wd[i][8*b +: 8];
  for (genvar p = 0; p < p_num_ports; p++) begin : g_port
    logic [46:0]   msg_q [p_depth];
    logic [GW-1:0] age_q [p_depth];
    logic [QW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    typ;
    logic [7:0]    opq;
    logic [31:0]   addr, data, bm, rd;
    logic [1:0]    len, off;
    logic [3:0]    mask;
    logic          acc, pop, unused;
    assign {typ, opq, addr, len, data} = m.req_msg[p];
    assign unused = ^addr[31:AW+2];
    assign mask = len == 2'd1 ? 4'h1 : len == 2'd2 ? 4'h3 : 4'hf;
    assign bm   = len == 2'd1 ? 32'hff : len == 2'd2 ? 32'hffff : 32'hffff_ffff;
    assign off  = len == 2'd1 ? addr[1:0] : len == 2'd2 ? {addr[1], 1'b0} : 2'b00;
    assign m.req_rdy[p]  = cnt_q != CW'(p_depth);
    assign acc           = m.req_val[p] & m.req_rdy[p];
    assign m.resp_val[p] = cnt_q != '0 && age_q[head_q] == GW'(p_lat - 1);
    assign pop           = m.resp_val[p] & m.resp_rdy[p];
    assign m.resp_msg[p] = m.resp_val[p] ? msg_q[head_q] : '0;
    assign wr[p]  = acc && (typ == 3'd1 || typ == 3'd2);
    assign idx[p] = addr[2 +: AW];
    assign be[p]  = mask << off;
    assign wd[p]  = data << {off, 3'b000};
    assign rd     = typ == 3'd0 ? (mem_q[idx[p]] >> {off, 3'b000}) & bm : '0;
    assign head_d = head_q == QW'(p_depth - 1) ? '0 : head_q + 1'b1;
    assign tail_d = tail_q == QW'(p_depth - 1) ? '0 : tail_q + 1'b1;
    assign cnt_d  = cnt_q + CW'(acc) - CW'(pop);
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (acc) tail_q <= tail_d;
        if (pop) head_q <= head_d;
        cnt_q <= cnt_d;
      end
    // read data is captured at accept, so later writes cannot alter a queued response
    always_ff @(posedge clk)
      for (int i = 0; i < p_depth; i++)
        if (acc && tail_q == QW'(i)) begin
          msg_q[i] <= {typ, opq, 2'b00, len, rd};
          age_q[i] <= '0;
        end else if (age_q[i] != GW'(p_lat - 1)) age_q[i] <= age_q[i] + 1'b1;
  end
endmodule

// File: tb/tb_test_mem_mp.sv
module tb_test_mem_mp;
  localparam int RD = 0, WR = 1, INIT = 2;
  logic clk = 0, rst = 0;
  int n_assert = 0, n_fail = 0;
  logic [46:0] sb [4][$];
  logic mv, mr;
  logic [46:0] mm, me;
  always #5 clk = ~clk;
  test_mem_mp_if #(.N(2)) b1();
  test_mem_mp_if #(.N(2)) b3();
  test_mem_mp #(.p_num_ports(2), .p_mem_words(4096), .p_lat(1), .p_depth(4)) d1(.clk(clk), .rst(rst), .m(b1));
  test_mem_mp #(.p_num_ports(2), .p_mem_words(4096), .p_lat(3), .p_depth(4)) d3(.clk(clk), .rst(rst), .m(b3));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input int d, input int p, input int t, input int o, input int a,
                      input int l, input int w, input int e);
    if (d == 0) begin
      b1.req_msg[p] = {3'(t), 8'(o), 32'(a), 2'(l), 32'(w)};
      b1.req_val[p] = 1'b1;
    end else begin
      b3.req_msg[p] = {3'(t), 8'(o), 32'(a), 2'(l), 32'(w)};
      b3.req_val[p] = 1'b1;
    end
    sb[2*d+p].push_back({3'(t), 8'(o), 2'b00, 2'(l), 32'(e)});
  endtask

  task automatic idle(input int d, input int p);
    if (d == 0) b1.req_val[p] = 1'b0;
    else b3.req_val[p] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 128'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 128'(0));
  endtask

  always @(negedge clk)
    if (!rst)
      for (int k = 0; k < 4; k++) begin
        mv = k < 2 ? b1.resp_val[k%2] : b3.resp_val[k%2];
        mr = k < 2 ? b1.resp_rdy[k%2] : b3.resp_rdy[k%2];
        mm = k < 2 ? b1.resp_msg[k%2] : b3.resp_msg[k%2];
        if (mv && mr) begin
          chk($sformatf("sb_nonempty%0d", k), 128'(sb[k].size() != 0), 128'(1));
          if (sb[k].size() != 0) begin
            me = sb[k].pop_front();
            chk($sformatf("resp%0d", k), 128'(mm), 128'(me));
          end
        end
      end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    b1.req_val = '0; b3.req_val = '0; b1.req_msg = '0; b3.req_msg = '0;
    b1.resp_rdy = '1; b3.resp_rdy = '1;
    #1 rst = 1;
    #2;
    chk("rst_val1", 128'(b1.resp_val), 128'(0));
    chk("rst_msg1", 128'(b1.resp_msg), 128'(0));
    chk("rst_val3", 128'(b3.resp_val), 128'(0));
    chk("rst_msg3", 128'(b3.resp_msg), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rdy1", 128'(b1.req_rdy), 128'(3));
    chk("rdy3", 128'(b3.req_rdy), 128'(3));
    // write then read, single-cycle latency
    send(0, 0, WR, 8'h11, 32'h100, 0, 32'hDEADBEEF, 0); tick(); idle(0, 0);
    @(negedge clk) chk("lat_wr", 128'(b1.resp_val[0]), 128'(1));
    send(0, 0, RD, 8'h22, 32'h100, 0, 0, 32'hDEADBEEF); tick(); idle(0, 0);
    @(negedge clk);
    chk("lat_rd", 128'(b1.resp_val[0]), 128'(1));
    chk("rd_msg", 128'(b1.resp_msg[0]), 128'({3'd0, 8'h22, 2'b00, 2'b00, 32'hDEADBEEF}));
    // sub-word accesses
    send(0, 0, WR, 1, 32'h200, 0, 32'h11223344, 0); tick();
    send(0, 0, WR, 2, 32'h203, 1, 32'hAA, 0); tick();
    send(0, 0, RD, 3, 32'h202, 2, 0, 32'hAA22); tick();
    send(0, 0, RD, 4, 32'h201, 1, 0, 32'h33); tick();
    send(0, 0, RD, 5, 32'h203, 2, 0, 32'hAA22); tick();
    send(0, 0, RD, 6, 32'h200, 0, 0, 32'hAA223344); tick(); idle(0, 0);
    // same-edge multi-port collisions
    send(0, 0, WR, 8, 32'h40, 0, 1, 0); send(0, 1, WR, 9, 32'h40, 0, 2, 0); tick();
    send(0, 0, WR, 10, 32'h40, 0, 3, 0); send(0, 1, RD, 11, 32'h40, 0, 0, 2); tick();
    send(0, 0, RD, 12, 32'h40, 0, 0, 3); send(0, 1, INIT, 13, 32'h204, 0, 32'hCAFEF00D, 0); tick();
    send(0, 0, WR, 14, 32'h44, 0, 32'h11111111, 0); send(0, 1, WR, 15, 32'h44, 1, 32'h22, 0); tick();
    send(0, 0, RD, 16, 32'h44, 0, 0, 32'h11111122); send(0, 1, RD, 17, 32'h204, 0, 0, 32'hCAFEF00D); tick();
    idle(0, 0); idle(0, 1);
    // address wrap and unknown type
    send(0, 1, WR, 20, 32'h4008, 0, 32'h55, 0); tick();
    send(0, 1, 3, 21, 32'h8, 0, 32'hFF, 0); tick();
    send(0, 1, RD, 22, 32'h8, 0, 0, 32'h55); tick(); idle(0, 1);
    drain();
    // p_lat=3 back-pressure and full queue on port 1
    for (int i = 0; i < 5; i++) begin send(1, 1, WR, i, 32'h10 + 4*i, 0, 32'hA0 + i, 0); tick(); end
    idle(1, 1);
    drain();
    b3.resp_rdy[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rdy_fill", 128'(b3.req_rdy[1]), 128'(1));
      send(1, 1, RD, 8'h30 + i, 32'h10 + 4*i, 0, 0, 32'hA0 + i); tick();
    end
    chk("rdy_full", 128'(b3.req_rdy[1]), 128'(0));
    send(1, 1, RD, 8'h34, 32'h20, 0, 0, 32'hA4);
    repeat (3) tick();
    chk("rdy_hold", 128'(b3.req_rdy[1]), 128'(0));
    chk("val_hold", 128'(b3.resp_val[1]), 128'(1));
    b3.resp_rdy[1] = 1'b1;
    @(negedge clk) chk("b2b0", 128'(b3.resp_val[1]), 128'(1));
    tick();
    chk("rdy_after_pop", 128'(b3.req_rdy[1]), 128'(1));
    @(negedge clk) chk("b2b1", 128'(b3.resp_val[1]), 128'(1));
    tick(); idle(1, 1);
    @(negedge clk) chk("b2b2", 128'(b3.resp_val[1]), 128'(1));
    tick();
    @(negedge clk) chk("b2b3", 128'(b3.resp_val[1]), 128'(1));
    tick();
    @(negedge clk) chk("fifth_val", 128'(b3.resp_val[1]), 128'(1));
    drain();
    // reset with responses in flight; array survives
    send(1, 0, WR, 40, 32'h300, 0, 32'h5A5A, 0); tick(); idle(1, 0);
    drain();
    b3.resp_rdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin send(1, 0, RD, 41 + i, 32'h300, 0, 0, 32'h5A5A); tick(); end
    idle(1, 0);
    @(negedge clk) chk("inflight", 128'(b3.resp_val[0]), 128'(1));
    #2 rst = 1;
    #1;
    chk("rst_mid_val", 128'(b3.resp_val), 128'(0));
    chk("rst_mid_msg", 128'(b3.resp_msg), 128'(0));
    sb[2].delete();
    @(posedge clk);
    #1 rst = 0;
    b3.resp_rdy[0] = 1'b1;
    repeat (5) @(negedge clk) chk("no_stale", 128'(b3.resp_val), 128'(0));
    send(1, 0, RD, 50, 32'h300, 0, 0, 32'h5A5A); tick(); idle(1, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
